// File: rtl/demux_pkg.sv
// Shared constants and types for the 8-lane buffered demultiplexer.
package demux_pkg;

   localparam int LANES = 8;
   localparam int SEL_W = 3;

   typedef logic [SEL_W-1:0] lane_idx_t;

   // Round-robin successor; the 3-bit width gives the 7 -> 0 wrap for free.
   function automatic lane_idx_t next_lane(input lane_idx_t cur);
      return cur + lane_idx_t'(1);
   endfunction

endpackage

// File: rtl/demux_lane.sv
// One output lane: a WIDTH-bit data register with an occupied flag.
// A load takes priority over an ack so a full lane can pass through bubble-free.
module demux_lane #(
   parameter int WIDTH = 3
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic             ack,
   input  logic [WIDTH-1:0] load_data,
   output logic [WIDTH-1:0] data,
   output logic             valid
);

   // Lane storage: load captures new data, ack alone frees the slot, otherwise hold.
   // NOTE: sequential state uses non-blocking (<=) so every lane samples the same pre-edge values.
   // NOTE: the data register is reset too, because out_data must read zero straight after reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         data  <= '0;
         valid <= 1'b0;
      end else if (load) begin
         data  <= load_data;
         valid <= 1'b1;
      end else if (ack) begin
         valid <= 1'b0;
      end
   end

endmodule

// File: rtl/demux8_buf.sv
// 8-lane buffered demultiplexer: routes each accepted word to one lane chosen
// either by in_sel or by a round-robin pointer, with per-lane consume strobes.
module demux8_buf
   import demux_pkg::*;
#(
   parameter int WIDTH = 3
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [WIDTH-1:0]       in_data,
   input  logic [SEL_W-1:0]       in_sel,
   input  logic                   auto_mode,
   output logic [LANES*WIDTH-1:0] out_data,
   output logic [LANES-1:0]       out_valid,
   input  logic [LANES-1:0]       out_ack,
   output logic [SEL_W-1:0]       rr_ptr,
   output logic                   frame_done
);

   lane_idx_t        dest;
   logic             accept;
   logic [LANES-1:0] load;

   // Destination choice and handshake; in_ready never looks at in_valid.
   // NOTE: every signal written here gets a default first, so no latch is inferred.
   always_comb begin
      load       = '0;
      dest       = auto_mode ? lane_idx_t'(rr_ptr) : lane_idx_t'(in_sel);
      in_ready   = ~out_valid[dest] | out_ack[dest];
      accept     = in_valid & in_ready;
      load[dest] = accept;
   end

   for (genvar i = 0; i < LANES; i++) begin : g_lane
      demux_lane #(
         .WIDTH(WIDTH)
      ) u_lane (
         .clk      (clk),
         .rst_n    (rst_n),
         .load     (load[i]),
         .ack      (out_ack[i]),
         .load_data(in_data),
         .data     (out_data[i*WIDTH +: WIDTH]),
         .valid    (out_valid[i])
      );
   end

   // Round-robin pointer advances only on auto-mode accepts; frame_done flags the lane-7 fill.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rr_ptr     <= '0;
         frame_done <= 1'b0;
      end else begin
         frame_done <= accept & auto_mode & (rr_ptr == SEL_W'(LANES - 1));
         if (accept && auto_mode) begin
            rr_ptr <= next_lane(rr_ptr);
         end
      end
   end

endmodule

// File: tb/tb_demux8_buf.sv
// Self-checking bench for demux8_buf: a reference model predicts each cycle's
// outputs, pushes them to a scoreboard queue, and they are popped and compared
// once the DUT has clocked.
module tb_demux8_buf;

   localparam int W = 3;

   typedef struct {
      logic [8*W-1:0] data;
      logic [7:0]     valid;
      logic [2:0]     ptr;
      logic           fd;
   } exp_t;

   logic           clk = 1'b0;
   logic           rst_n;
   logic           in_valid;
   logic           in_ready;
   logic [W-1:0]   in_data;
   logic [2:0]     in_sel;
   logic           auto_mode;
   logic [8*W-1:0] out_data;
   logic [7:0]     out_valid;
   logic [7:0]     out_ack;
   logic [2:0]     rr_ptr;
   logic           frame_done;

   int n_tests = 0;
   int n_fail  = 0;

   exp_t sb[$];

   // reference model state
   logic [W-1:0] m_data[8];
   logic [7:0]   m_valid;
   logic [2:0]   m_ptr;
   logic         m_fd;

   demux8_buf #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_sel    (in_sel),
      .auto_mode (auto_mode),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ack   (out_ack),
      .rr_ptr    (rr_ptr),
      .frame_done(frame_done)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [8*W-1:0] pack_model();
      logic [8*W-1:0] v;
      for (int i = 0; i < 8; i++) v[i*W +: W] = m_data[i];
      return v;
   endfunction

   // One cycle: drive at negedge, predict, clock, compare at the next negedge.
   task automatic step(input logic r, input logic v, input logic [W-1:0] d,
                       input logic [2:0] sel, input logic a, input logic [7:0] k);
      logic [2:0] dst;
      logic       rdy, acc;
      exp_t       e;
      rst_n = r; in_valid = v; in_data = d; in_sel = sel; auto_mode = a; out_ack = k;
      #1;
      dst = a ? m_ptr : sel;
      rdy = !m_valid[dst] || k[dst];
      acc = v && rdy;
      if (r) check("in_ready", 32'(in_ready), 32'(rdy));
      if (!r) begin
         for (int i = 0; i < 8; i++) m_data[i] = '0;
         m_valid = '0; m_ptr = '0; m_fd = 1'b0;
      end else begin
         for (int i = 0; i < 8; i++) begin
            if (acc && dst == 3'(i)) begin
               m_data[i] = d; m_valid[i] = 1'b1;
            end else if (k[i]) begin
               m_valid[i] = 1'b0;
            end
         end
         m_fd = acc && a && (dst == 3'd7);
         if (acc && a) m_ptr = (m_ptr == 3'd7) ? 3'd0 : m_ptr + 3'd1;
      end
      e.data = pack_model(); e.valid = m_valid; e.ptr = m_ptr; e.fd = m_fd;
      sb.push_back(e);
      @(negedge clk);
      check("sb_depth", 32'(sb.size()), 32'd1);
      if (sb.size() > 0) begin
         e = sb.pop_front();
         check("out_data",   32'(out_data),   32'(e.data));
         check("out_valid",  32'(out_valid),  32'(e.valid));
         check("rr_ptr",     32'(rr_ptr),     32'(e.ptr));
         check("frame_done", 32'(frame_done), 32'(e.fd));
      end
   endtask

   initial begin
      for (int i = 0; i < 8; i++) m_data[i] = '0;
      m_valid = '0; m_ptr = '0; m_fd = 1'b0;
      rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_sel = '0; auto_mode = 1'b0; out_ack = '0;
      @(negedge clk);

      // reset with accept and ack attempts present: all discarded
      step(1'b0, 1'b1, 3'd5, 3'd2, 1'b1, 8'hFF);
      step(1'b0, 1'b1, 3'd6, 3'd0, 1'b0, 8'h00);
      check("rst_valid", 32'(out_valid), 32'h00);
      check("rst_data",  32'(out_data),  32'h0);

      // auto fill of lanes 0..7, frame_done after the 8th accept
      for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 3'(i), 3'd0, 1'b1, 8'h00);
      check("fill_valid", 32'(out_valid), 32'hFF);
      check("fill_ptr",   32'(rr_ptr),    32'd0);
      check("fill_fd",    32'(frame_done), 32'd1);
      for (int i = 0; i < 8; i++) check("fill_lane", 32'(out_data[i*W +: W]), 32'(i));
      step(1'b1, 1'b0, 3'd0, 3'd0, 1'b1, 8'h00);
      check("fd_one_cycle", 32'(frame_done), 32'd0);

      // full: stall, then pass-through on lane 0 with ack
      step(1'b1, 1'b1, 3'd3, 3'd0, 1'b1, 8'h00);
      step(1'b1, 1'b1, 3'd5, 3'd0, 1'b1, 8'h01);
      check("pass_lane0", 32'(out_data[0 +: W]), 32'd5);
      check("pass_valid", 32'(out_valid), 32'hFF);
      check("pass_ptr",   32'(rr_ptr), 32'd1);

      // drain everything, then ack on empty lanes is ignored
      step(1'b1, 1'b0, 3'd0, 3'd0, 1'b1, 8'hFF);
      step(1'b1, 1'b0, 3'd0, 3'd0, 1'b1, 8'hFF);
      check("empty_ack_valid", 32'(out_valid), 32'h00);

      // explicit select: stall on occupied lane 3, ack, then accept
      step(1'b1, 1'b1, 3'd6, 3'd3, 1'b0, 8'h00);
      step(1'b1, 1'b1, 3'd2, 3'd3, 1'b0, 8'h00);
      check("stall_lane3", 32'(out_data[3*W +: W]), 32'd6);
      step(1'b1, 1'b0, 3'd2, 3'd3, 1'b0, 8'h08);
      check("ack_lane3", 32'(out_valid[3]), 32'd0);
      step(1'b1, 1'b1, 3'd2, 3'd3, 1'b0, 8'h00);
      check("accept_lane3", 32'(out_data[3*W +: W]), 32'd2);

      // pointer to 5, manual accept keeps it, auto resumes at lane 5
      step(1'b1, 1'b0, 3'd0, 3'd0, 1'b1, 8'hFF);
      for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 3'(i + 1), 3'd0, 1'b1, 8'h00);
      check("ptr_at5", 32'(rr_ptr), 32'd5);
      step(1'b1, 1'b1, 3'd7, 3'd1, 1'b0, 8'h02);
      check("toggle_ptr", 32'(rr_ptr), 32'd5);
      step(1'b1, 1'b1, 3'd4, 3'd1, 1'b1, 8'h00);
      check("resume_lane5", 32'(out_data[5*W +: W]), 32'd4);
      check("resume_ptr",   32'(rr_ptr), 32'd6);

      // mid-frame reset
      step(1'b0, 1'b0, 3'd0, 3'd0, 1'b1, 8'h00);
      for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 3'(7 - i), 3'd0, 1'b1, 8'h00);
      step(1'b0, 1'b1, 3'd3, 3'd0, 1'b1, 8'h00);
      check("mid_rst_ptr", 32'(rr_ptr), 32'd0);
      step(1'b1, 1'b1, 3'd6, 3'd0, 1'b1, 8'h00);
      check("post_rst_valid", 32'(out_valid), 32'h01);
      check("post_rst_lane0", 32'(out_data[0 +: W]), 32'd6);

      // random traffic
      for (int n = 0; n < 200; n++)
         step(1'b1, 1'($urandom_range(0, 1)), 3'($urandom), 3'($urandom), 1'($urandom_range(0, 1)),
              8'($urandom) & 8'($urandom));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/demux8_buf.md
DEMUX8_BUF -- requirements
Module: demux8_buf

Interface
REQ-001 Parameter WIDTH, default 3, SHALL set the data width of the input word and of each output lane.
REQ-002 clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-003 rst_n  input  1  SHALL be the reset, synchronous and active-low.
REQ-004 in_valid  input  1  SHALL indicate that the input word is valid.
REQ-005 in_ready  output  1  SHALL indicate that the block accepts the word this cycle.
REQ-006 in_data  input  WIDTH  SHALL carry the input word.
REQ-007 in_sel  input  3  SHALL carry the destination lane index, used only when auto_mode=0.
REQ-008 auto_mode  input  1  SHALL select round-robin destination when 1, and in_sel destination when 0.
REQ-009 out_data  output  8xWIDTH  SHALL carry the per-lane registered data; lane i occupies bits [i*WIDTH +: WIDTH].
REQ-010 out_valid  output  8  SHALL carry per-lane occupied flags.
REQ-011 out_ack  input  8  SHALL carry per-lane consume strobes.
REQ-012 rr_ptr  output  3  SHALL show the current round-robin lane pointer.
REQ-013 frame_done  output  1  SHALL pulse for one cycle after lane 7 is filled in auto mode.

Function
REQ-014 Destination dest SHALL be rr_ptr when auto_mode=1, else in_sel, evaluated combinationally each cycle.
REQ-015 in_ready SHALL equal (~out_valid[dest] | out_ack[dest]), combinationally, with no dependency on in_valid.
REQ-016 An accept SHALL occur when in_valid & in_ready; on the next edge out_data[dest] <= in_data and out_valid[dest] <= 1.
REQ-017 Accept-to-out_valid latency SHALL be exactly 1 cycle.
REQ-018 out_ack[i] with out_valid[i]=1 and no same-cycle accept into lane i SHALL clear out_valid[i] on the next edge.
REQ-019 A simultaneous out_ack[i] and accept into lane i SHALL leave out_valid[i]=1 with the new data, so that a full lane passes through without a bubble.
REQ-020 out_ack[i] on a lane with out_valid[i]=0 SHALL be ignored.
REQ-021 Lanes not targeted by an accept SHALL hold their out_data unchanged; out_data SHALL also hold after an ack.
REQ-022 rr_ptr SHALL increment by 1 on each accept with auto_mode=1, wrapping 7->0, and SHALL hold otherwise.
REQ-023 Toggling auto_mode SHALL NOT alter rr_ptr.
REQ-024 frame_done SHALL be a registered 1 in the cycle after an auto-mode accept into lane 7, and 0 otherwise.
REQ-025 While in_ready=0, in_valid held high SHALL cause no state change; the upstream holds its word.

Reset
REQ-026 With rst_n=0 at a clk edge: out_data=0, out_valid=8'h00, rr_ptr=0, frame_done=0, regardless of in_valid or out_ack.
REQ-027 An accept presented in the same cycle as reset SHALL be discarded.
REQ-028 After rst_n rises, in_ready SHALL be 1 for every dest.

Structure
REQ-029 Package demux_pkg SHALL hold LANES=8, SEL_W=3, and typedef lane_idx_t (logic [SEL_W-1:0]).
REQ-030 One sub-module, demux_lane (single WIDTH-bit data register plus valid flag, with load/ack inputs), SHALL be instantiated 8 times via generate.
REQ-031 Pointer, dest and frame_done logic SHALL reside in demux8_buf.

Verification
REQ-032 Reset, then auto_mode=1 with 8 back-to-back words 0..7 (WIDTH=3), out_ack=0 -> lane i holds i; out_valid=8'hFF; rr_ptr=0; frame_done high exactly one cycle after the 8th accept.
REQ-033 All lanes full, auto_mode=1, in_valid=1 -> in_ready=0, no change; then out_ack=8'h01 with in_data=5 -> lane0=5, out_valid stays 8'hFF, rr_ptr=1.
REQ-034 auto_mode=0: in_sel=3 with data 6, then in_sel=3 with data 2 and no ack -> second word stalled, lane3=6; pulse out_ack[3] -> lane3 cleared, then next word accepted -> lane3=2.
REQ-035 out_ack=8'hFF with all lanes empty -> out_valid remains 8'h00, out_data unchanged.
REQ-036 Mid-frame (rr_ptr=4, lanes 0-3 valid), assert rst_n=0 for one cycle with in_valid=1 -> all outputs zero; first post-reset accept lands in lane 0.
REQ-037 Toggling auto_mode at rr_ptr=5 with in_sel=1 accepts -> rr_ptr stays 5; on return to auto mode, next accept lands in lane 5.
